fmul_normalize_round: RTL and testbench

- Pipelined normalize-and-round stage placed directly downstream of the 16x16 mantissa multiplier in the pipelined floating-point multiplier.
- Consumes the raw 32-bit mantissa product, plus the sign and pre-biased exponent sum from the upstream exponent path.
- Produces a normalized 1.15 mantissa and an 8-bit biased exponent, with overflow and underflow flags.
- Two register stages; valid/ready handshake on both sides; throughput of 1 result per cycle.

---
 rtl/fmul_normalize_round.sv | 160 ++++++++++++++++
 tb/tb_fmul_normalize_round.sv | 213 +++++++++++++++++++++
 2 files changed

// File: rtl/fmul_normalize_round.sv
// Two-stage normalize-and-round stage for the pipelined FP multiplier mantissa path.
// Define FMUL_ROUND_NEAREST_EN for round-to-nearest-even; otherwise the mantissa is truncated.
module fmul_normalize_round #(
    parameter int BIAS    = 127,
    parameter int EXP_MAX = 255
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [31:0] in_prod,
    input  logic [9:0]  in_exp,
    input  logic        in_sign,
    input  logic        in_zero,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [15:0] out_mant,
    output logic [7:0]  out_exp,
    output logic        out_sign,
    output logic        out_ovf,
    output logic        out_unf
);

    localparam logic signed [10:0] EXP_MAX_S = 11'(EXP_MAX);

    // The biased range must hold an unbiased exponent of zero.
    if (BIAS <= 0 || BIAS >= EXP_MAX) begin : g_bad_bias
        $error("fmul_normalize_round: BIAS must lie inside (0, EXP_MAX)");
    end

    logic               s1_valid;
    logic               s1_sign;
    logic               s1_zero;
    logic [15:0]        s1_mant;
    logic signed [10:0] s1_exp;

    logic               s1_adv;
    logic               s2_adv;

    logic [15:0]        n_mant;
    logic signed [10:0] n_exp;
    logic [15:0]        r_mant;
    logic signed [10:0] r_exp;

    assign s2_adv   = !out_valid || out_ready;
    assign s1_adv   = !s1_valid || s2_adv;
    assign in_ready = s1_adv;

`ifdef FMUL_ROUND_NEAREST_EN
    logic s1_guard;
    logic s1_sticky;
    logic n_guard;
    logic n_sticky;

    // NOTE: every variable driven here gets a default first so no latch is inferred.
    always_comb begin
        n_exp    = {in_exp[9], in_exp} + 11'(in_prod[31]);
        n_mant   = in_prod[30:15];
        n_guard  = in_prod[14];
        n_sticky = |in_prod[13:0];
        if (in_prod[31]) begin
            n_mant   = in_prod[31:16];
            n_guard  = in_prod[15];
            n_sticky = |in_prod[14:0];
        end
    end

    always_comb begin
        r_mant = s1_mant;
        r_exp  = s1_exp;
        if (s1_guard && (s1_sticky || s1_mant[0])) begin
            // A carry out of 16 bits lands exactly on the next power of two.
            if (&s1_mant) begin
                r_mant = 16'h8000;
                r_exp  = s1_exp + 11'sd1;
            end else begin
                r_mant = s1_mant + 16'd1;
            end
        end
    end
`else
    logic unused_low_bits;
    assign unused_low_bits = ^in_prod[14:0];

    always_comb begin
        n_exp  = {in_exp[9], in_exp} + 11'(in_prod[31]);
        n_mant = in_prod[31] ? in_prod[31:16] : in_prod[30:15];
    end

    always_comb begin
        r_mant = s1_mant;
        r_exp  = s1_exp;
    end
`endif

    // NOTE: registered state uses non-blocking assignments so all flops update together.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            s1_valid  <= 1'b0;
            s1_sign   <= 1'b0;
            s1_zero   <= 1'b0;
            s1_mant   <= '0;
            s1_exp    <= '0;
`ifdef FMUL_ROUND_NEAREST_EN
            s1_guard  <= 1'b0;
            s1_sticky <= 1'b0;
`endif
        end else if (s1_adv) begin
            s1_valid <= in_valid;
            if (in_valid) begin
                s1_sign   <= in_sign;
                s1_zero   <= in_zero;
                s1_mant   <= n_mant;
                s1_exp    <= n_exp;
`ifdef FMUL_ROUND_NEAREST_EN
                s1_guard  <= n_guard;
                s1_sticky <= n_sticky;
`endif
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            out_valid <= 1'b0;
            out_mant  <= '0;
            out_exp   <= '0;
            out_sign  <= 1'b0;
            out_ovf   <= 1'b0;
            out_unf   <= 1'b0;
        end else if (s2_adv) begin
            out_valid <= s1_valid;
            if (s1_valid) begin
                out_sign <= s1_sign;
                if (s1_zero) begin
                    out_mant <= '0;
                    out_exp  <= '0;
                    out_ovf  <= 1'b0;
                    out_unf  <= 1'b0;
                end else if (r_exp >= EXP_MAX_S) begin
                    out_mant <= 16'h8000;
                    out_exp  <= 8'hFF;
                    out_ovf  <= 1'b1;
                    out_unf  <= 1'b0;
                end else if (r_exp <= 11'sd0) begin
                    out_mant <= '0;
                    out_exp  <= '0;
                    out_ovf  <= 1'b0;
                    out_unf  <= 1'b1;
                end else begin
                    out_mant <= r_mant;
                    out_exp  <= r_exp[7:0];
                    out_ovf  <= 1'b0;
                    out_unf  <= 1'b0;
                end
            end
        end
    end

endmodule

// File: tb/tb_fmul_normalize_round.sv
// Directed bench for fmul_normalize_round: arithmetic vectors, range limits, backpressure, async reset.
// Expected values follow the build: FMUL_ROUND_NEAREST_EN selects rounding, otherwise truncation.
module tb_fmul_normalize_round;

    logic        clk;
    logic        reset;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] in_prod;
    logic [9:0]  in_exp;
    logic        in_sign;
    logic        in_zero;
    logic        out_valid;
    logic        out_ready;
    logic [15:0] out_mant;
    logic [7:0]  out_exp;
    logic        out_sign;
    logic        out_ovf;
    logic        out_unf;

    int vectors     = 0;
    int miscompares = 0;

    fmul_normalize_round dut (
        .clk       (clk),
        .reset     (reset),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_prod   (in_prod),
        .in_exp    (in_exp),
        .in_sign   (in_sign),
        .in_zero   (in_zero),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_mant  (out_mant),
        .out_exp   (out_exp),
        .out_sign  (out_sign),
        .out_ovf   (out_ovf),
        .out_unf   (out_unf)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // {sign, ovf, unf, exp[7:0], mant[15:0]}
    function automatic logic [31:0] res(input logic s, input logic o, input logic u,
                                        input logic [7:0] e, input logic [15:0] m);
        return {5'd0, s, o, u, e, m};
    endfunction

    function automatic logic [31:0] out_bus();
        return res(out_sign, out_ovf, out_unf, out_exp, out_mant);
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp)
        else begin
            miscompares++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Called at a falling edge; returns at the falling edge where the result is visible.
    task automatic send_one(input string tag, input logic [31:0] prod, input logic [9:0] e,
                            input logic s, input logic z, input logic [31:0] expect_res);
        in_valid  = 1'b1;
        in_prod   = prod;
        in_exp    = e;
        in_sign   = s;
        in_zero   = z;
        out_ready = 1'b1;
        #1 check({tag, " in_ready"}, 32'(in_ready), 32'd1);
        @(negedge clk);
        in_valid = 1'b0;
        #1 check({tag, " lat1"}, 32'(out_valid), 32'd0);
        @(negedge clk);
        #1 check({tag, " lat2"}, 32'(out_valid), 32'd1);
        check({tag, " res"}, out_bus(), expect_res);
    endtask

    logic [31:0] bp_prod [4];
    logic [9:0]  bp_exp  [4];
    logic        bp_sign [4];
    logic [31:0] bp_res  [4];

    initial begin
        reset     = 1'b1;
        in_valid  = 1'b0;
        in_prod   = '0;
        in_exp    = '0;
        in_sign   = 1'b0;
        in_zero   = 1'b0;
        out_ready = 1'b1;

        #2 check("reset out_valid", 32'(out_valid), 32'd0);
        check("reset outputs", out_bus(), 32'd0);
        @(negedge clk);
        reset = 1'b0;
        #1 check("idle in_ready", 32'(in_ready), 32'd1);
        @(negedge clk);

        send_one("one_x_one", 32'h4000_0000, 10'd127, 1'b0, 1'b0, res(0, 0, 0, 8'd127, 16'h8000));
        @(negedge clk);
        send_one("1p5_x_1p5", 32'h9000_0000, 10'd127, 1'b1, 1'b0, res(1, 0, 0, 8'd128, 16'h9000));
        @(negedge clk);
`ifdef FMUL_ROUND_NEAREST_EN
        send_one("tie_even", 32'h4000_4000, 10'd127, 1'b0, 1'b0, res(0, 0, 0, 8'd127, 16'h8000));
        @(negedge clk);
        send_one("tie_odd", 32'h4000_C000, 10'd127, 1'b0, 1'b0, res(0, 0, 0, 8'd127, 16'h8002));
        @(negedge clk);
        send_one("round_carry", 32'h7FFF_C000, 10'd100, 1'b0, 1'b0, res(0, 0, 0, 8'd101, 16'h8000));
        @(negedge clk);
        send_one("carry_ovf", 32'h7FFF_C000, 10'd254, 1'b0, 1'b0, res(0, 1, 0, 8'd255, 16'h8000));
        @(negedge clk);
`else
        send_one("tie_even", 32'h4000_4000, 10'd127, 1'b0, 1'b0, res(0, 0, 0, 8'd127, 16'h8000));
        @(negedge clk);
        send_one("tie_odd", 32'h4000_C000, 10'd127, 1'b0, 1'b0, res(0, 0, 0, 8'd127, 16'h8001));
        @(negedge clk);
        send_one("round_carry", 32'h7FFF_C000, 10'd100, 1'b0, 1'b0, res(0, 0, 0, 8'd100, 16'hFFFF));
        @(negedge clk);
        send_one("carry_ovf", 32'h7FFF_C000, 10'd254, 1'b0, 1'b0, res(0, 0, 0, 8'd254, 16'hFFFF));
        @(negedge clk);
`endif
        send_one("ovf_edge", 32'h9000_0000, 10'd254, 1'b0, 1'b0, res(0, 1, 0, 8'd255, 16'h8000));
        @(negedge clk);
        send_one("below_ovf", 32'h9000_0000, 10'd253, 1'b1, 1'b0, res(1, 0, 0, 8'd254, 16'h9000));
        @(negedge clk);
        send_one("ovf_big", 32'h4000_0000, 10'd300, 1'b1, 1'b0, res(1, 1, 0, 8'd255, 16'h8000));
        @(negedge clk);
        send_one("unf_zero", 32'h4000_0000, 10'd0, 1'b0, 1'b0, res(0, 0, 1, 8'd0, 16'h0000));
        @(negedge clk);
        send_one("unf_neg", 32'h4000_0000, 10'h3FB, 1'b1, 1'b0, res(1, 0, 1, 8'd0, 16'h0000));
        @(negedge clk);
        send_one("exp_one", 32'h4000_0000, 10'd1, 1'b0, 1'b0, res(0, 0, 0, 8'd1, 16'h8000));
        @(negedge clk);
        send_one("zero_op", 32'h0000_0000, 10'd50, 1'b1, 1'b1, res(1, 0, 0, 8'd0, 16'h0000));
        @(negedge clk);
        send_one("zero_over_ovf", 32'h9000_0000, 10'd300, 1'b0, 1'b1, res(0, 0, 0, 8'd0, 16'h0000));
        @(negedge clk);

        // Backpressure: out_ready low for three cycles starting at the first out_valid.
        bp_prod[0] = 32'h4000_0000; bp_exp[0] = 10'd10; bp_sign[0] = 1'b1; bp_res[0] = res(1, 0, 0, 8'd10, 16'h8000);
        bp_prod[1] = 32'h9000_0000; bp_exp[1] = 10'd20; bp_sign[1] = 1'b0; bp_res[1] = res(0, 0, 0, 8'd21, 16'h9000);
        bp_prod[2] = 32'h6000_0000; bp_exp[2] = 10'd30; bp_sign[2] = 1'b1; bp_res[2] = res(1, 0, 0, 8'd30, 16'hC000);
        bp_prod[3] = 32'hC000_0000; bp_exp[3] = 10'd40; bp_sign[3] = 1'b0; bp_res[3] = res(0, 0, 0, 8'd41, 16'hC000);
        begin
            int          sent  = 0;
            int          rcvd  = 0;
            int          stall = 0;
            logic        seen  = 1'b0;
            logic        held  = 1'b0;
            logic [31:0] held_val = '0;
            in_zero = 1'b0;
            for (int cyc = 0; cyc < 40 && rcvd < 4; cyc++) begin
                if (out_valid) seen = 1'b1;
                out_ready = !(seen && stall < 3);
                in_valid  = (sent < 4);
                if (sent < 4) begin
                    in_prod = bp_prod[sent];
                    in_exp  = bp_exp[sent];
                    in_sign = bp_sign[sent];
                end
                #1;
                if (held) check("bp stable", {31'd0, out_valid} ^ out_bus(), {31'd0, 1'b1} ^ held_val);
                if (seen && stall == 0 && !out_ready)
                    check("bp in_ready drop", {31'(sent), in_ready}, {31'd2, 1'b0});
                if (out_valid && out_ready) begin
                    check($sformatf("bp result %0d", rcvd), out_bus(), bp_res[rcvd]);
                    rcvd++;
                end
                held     = out_valid && !out_ready;
                held_val = out_bus();
                if (seen && !out_ready) stall++;
                if (in_valid && in_ready) sent++;
                @(negedge clk);
            end
            in_valid  = 1'b0;
            out_ready = 1'b1;
            check("bp all received", 32'(rcvd), 32'd4);
            #1 check("bp no duplicate", 32'(out_valid), 32'd0);
            @(negedge clk);
        end

        // Async reset between edges with two beats in flight.
        in_valid = 1'b1;
        in_prod  = 32'h4000_0000;
        in_exp   = 10'd60;
        in_sign  = 1'b0;
        @(negedge clk);
        in_prod  = 32'h9000_0000;
        in_exp   = 10'd70;
        @(negedge clk);
        in_valid = 1'b0;
        #1 check("rst pre out_valid", 32'(out_valid), 32'd1);
        #1 reset = 1'b1;
        #1 check("rst async out_valid", 32'(out_valid), 32'd0);
        check("rst async outputs", out_bus(), 32'd0);
        @(negedge clk);
        reset = 1'b0;
        #1 check("rst release in_ready", 32'(in_ready), 32'd1);
        @(negedge clk);
        #1 check("rst flushed", 32'(out_valid), 32'd0);
        @(negedge clk);
        send_one("post_reset", 32'h9000_0000, 10'd100, 1'b1, 1'b0, res(1, 0, 0, 8'd101, 16'h9000));
        @(negedge clk);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
